// File: rtl/pci_bus_monitor.sv
// Passive PCI bus monitor: decodes each transaction into a record and queues it in a small FIFO.
// Define PCI_MON_SIG_EN to build the XOR data signature; otherwise rec_sig is tied to zero.
module pci_bus_monitor #(
    parameter int DEPTH      = 4,
    parameter int DEVSEL_TMO = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              AD,
    input  logic [3:0]               C_BE,
    input  logic                     FRAME,
    input  logic                     IRDY,
    input  logic                     TRDY,
    input  logic                     DEVSEL,
    input  logic [4:0]               GNT,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [31:0]              rec_addr,
    output logic [3:0]               rec_cmd,
    output logic [2:0]               rec_master,
    output logic [7:0]               rec_beats,
    output logic                     rec_abort,
    output logic [31:0]              rec_sig,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [1:0]               o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(DEVSEL_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(DEVSEL_TMO - 1);

    // Handshake: a record transfers on any rising edge where rec_valid and rec_ready are both 1;
    // rec_valid never drops and rec_* never change until that transfer happens.

    typedef enum logic [1:0] {
        S_SYNC      = 2'd0,
        S_IDLE      = 2'd1,
        S_ADDR_WAIT = 2'd2,
        S_DATA      = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic [2:0]  master;
        logic [7:0]  beats;
        logic        abort;
        logic [31:0] sig;
    } rec_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_frame_prev;
    logic            w_capture;
    logic            w_push;
    logic            w_beat;
    logic            w_abort_set;
    logic            w_tmo_inc;
    logic [2:0]      w_master;

    logic [31:0]     r_addr;
    logic [3:0]      r_cmd;
    logic [2:0]      r_master;
    logic [7:0]      r_beats;
    logic            r_abort;
    logic [TW-1:0]   r_tmo;
    logic [31:0]     w_sig;

    rec_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic            w_pop;
    logic            w_full;
    logic            w_wr;
    rec_t            w_rec;
    rec_t            w_head;

    always_comb begin
        w_master = 3'd7;
        if ($onehot(~GNT)) begin
            for (int i = 0; i < 5; i++) begin
                if (!GNT[i]) w_master = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SYNC;
            r_frame_prev <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_prev <= FRAME;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_push      = 1'b0;
        w_beat      = 1'b0;
        w_abort_set = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (FRAME && IRDY) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!FRAME && r_frame_prev) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_ADDR_WAIT;
                end
            end
            S_ADDR_WAIT: begin
                if (!DEVSEL) begin
                    w_beat      = !IRDY && !TRDY;
                    w_state_nxt = S_DATA;
                end else if (r_tmo == TMO_LAST) begin
                    w_abort_set = 1'b1;
                    w_state_nxt = S_DATA;
                end else begin
                    w_tmo_inc   = 1'b1;
                end
            end
            S_DATA: begin
                w_beat = !IRDY && !TRDY;
                // IRDY released after FRAME went high ends the transaction; FRAME low on that
                // same edge is a fast back-to-back address phase.
                if (IRDY && (FRAME || r_frame_prev)) begin
                    w_push = 1'b1;
                    if (!FRAME) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_ADDR_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_cmd    <= '0;
            r_master <= '0;
            r_beats  <= '0;
            r_abort  <= 1'b0;
            r_tmo    <= '0;
        end else if (w_capture) begin
            r_addr   <= AD;
            r_cmd    <= C_BE;
            r_master <= w_master;
            r_beats  <= '0;
            r_abort  <= 1'b0;
            r_tmo    <= '0;
        end else begin
            if (w_tmo_inc) r_tmo <= r_tmo + TW'(1);
            if (w_abort_set) r_abort <= 1'b1;
            if (w_beat && (r_beats != 8'hFF)) r_beats <= r_beats + 8'd1;
        end
    end

`ifdef PCI_MON_SIG_EN
    logic [31:0] r_sig;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (w_capture) begin
            r_sig <= '0;
        end else if (w_beat) begin
            r_sig <= r_sig ^ AD;
        end
    end
    assign w_sig = r_sig;
`else
    assign w_sig = 32'h0;
`endif

    assign w_rec = '{addr: r_addr, cmd: r_cmd, master: r_master, beats: r_beats,
                     abort: r_abort, sig: w_sig};

    assign w_pop  = rec_valid && rec_ready;
    assign w_full = (r_count == CW'(DEPTH));
    // A full FIFO still accepts the record when the head leaves on the same edge.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_rec;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign rec_valid   = (r_count != '0);
    assign rec_addr    = w_head.addr;
    assign rec_cmd     = w_head.cmd;
    assign rec_master  = w_head.master;
    assign rec_beats   = w_head.beats;
    assign rec_abort   = w_head.abort;
    assign rec_sig     = w_head.sig;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule
